// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one sram-like memory port between the fetch and
// execute stages. The execute (data) side has fixed priority, and a request
// that has been presented but not accepted holds the grant. An in-order tag
// FIFO records the source of each accepted request so that every response
// goes back to the requester that issued it.
module mem_req_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [2:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        m_req,
    output logic        m_wr,
    output logic [2:0]  m_size,
    output logic [31:0] m_addr,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,

    output logic        idle
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t     state_reg, state_next;
    logic            lock_src_reg, lock_src_next;   // 0 = inst, 1 = data
    logic [PW-1:0]   wptr_reg, rptr_reg;
    logic [CW-1:0]   count_reg, count_next;
    logic            tag_mem [DEPTH];

    logic            lock_hold;
    logic            sel;
    logic            req_sel;
    logic            full;
    logic            push;
    logic            pop;
    logic            head_tag;

    // Source selection, downstream request and acceptance strobes.
    // A locked source whose requester has dropped its request (flush) no
    // longer holds the grant, so the other requester can win this same cycle.
    always_comb begin
        lock_hold    = (state_reg == LOCKED) && (lock_src_reg ? data_req : inst_req);
        sel          = lock_hold ? lock_src_reg : data_req;
        req_sel      = sel ? data_req : inst_req;
        full         = (count_reg == CW'(DEPTH));
        m_req        = req_sel && !full;
        m_wr         = 1'b0;
        m_size       = 3'd0;
        m_addr       = 32'd0;
        m_wstrb      = 4'd0;
        m_wdata      = 32'd0;
        if (m_req) begin
            if (sel) begin
                m_wr    = data_wr;
                m_size  = data_size;
                m_addr  = data_addr;
                m_wstrb = data_wstrb;
                m_wdata = data_wdata;
            end else begin
                m_size  = 3'd2;
                m_addr  = inst_addr;
            end
        end
        push         = m_req && m_addr_ok;
        inst_addr_ok = push && !sel;
        data_addr_ok = push && sel;
    end

    // Response routing from the tag at the FIFO head; stray responses on an
    // empty FIFO are ignored.
    always_comb begin
        pop          = m_data_ok && (count_reg != CW'(0));
        head_tag     = tag_mem[rptr_reg];
        inst_data_ok = pop && !head_tag;
        data_data_ok = pop && head_tag;
        inst_rdata   = m_rdata;
        data_rdata   = m_rdata;
        idle         = (count_reg == CW'(0));
    end

    // Lock next-state: hold the grant on a presented-but-refused request.
    always_comb begin
        state_next    = state_reg;
        lock_src_next = lock_src_reg;
        if (lock_hold) begin
            if (m_addr_ok) begin
                state_next = UNLOCKED;
            end
        end else begin
            state_next = UNLOCKED;
            if (m_req && !m_addr_ok) begin
                state_next    = LOCKED;
                lock_src_next = sel;
            end
        end
    end

    // Occupancy next-state: simultaneous push and pop leaves count unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Lock, pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= UNLOCKED;
            lock_src_reg <= 1'b0;
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            lock_src_reg <= lock_src_next;
            count_reg    <= count_next;
            if (push) begin
                wptr_reg <= wptr_reg + PW'(1);
            end
            if (pop) begin
                rptr_reg <= rptr_reg + PW'(1);
            end
        end
    end

    // Tag FIFO storage: one entry per slot, written with the granted source.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tag
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    tag_mem[gi] <= 1'b0;
                end else if (push && (wptr_reg == PW'(gi))) begin
                    tag_mem[gi] <= sel;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed testbench for mem_req_arbiter (DEPTH = 4). Inputs change on the
// falling edge, outputs are compared 1 ns later, state updates on the rising
// edge.
module tb_mem_req_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [2:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        m_req, m_wr;
    logic [2:0]  m_size;
    logic [31:0] m_addr;
    logic [3:0]  m_wstrb;
    logic [31:0] m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;
    logic        idle;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_req_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_wstrb(m_wstrb), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .idle(idle)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("check %s ok (0x%08h)", tag, got);
        end
    endtask

    // Advance to the next falling edge (one rising edge passes on the way).
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0; inst_req = 1'b0; inst_addr = 32'd0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 3'd0; data_addr = 32'd0;
        data_wstrb = 4'd0; data_wdata = 32'd0;
        m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'd0;

        // ---- reset state ----
        cyc(); cyc(); #1;
        check_eq("rst_idle", 32'(idle), 32'd1);
        check_eq("rst_m_req", 32'(m_req), 32'd0);
        check_eq("rst_m_size", 32'(m_size), 32'd0);
        check_eq("rst_iaok", 32'(inst_addr_ok), 32'd0);
        check_eq("rst_daok", 32'(data_addr_ok), 32'd0);
        check_eq("rst_idok", 32'(inst_data_ok), 32'd0);
        check_eq("rst_ddok", 32'(data_data_ok), 32'd0);
        resetn = 1'b1;

        // ---- priority: data wins, then inst; responses data, inst ----
        cyc();
        inst_req = 1'b1; inst_addr = 32'h100;
        data_req = 1'b1; data_wr = 1'b0; data_size = 3'd2; data_addr = 32'h200;
        m_addr_ok = 1'b1; #1;
        check_eq("pri_daok", 32'(data_addr_ok), 32'd1);
        check_eq("pri_iaok0", 32'(inst_addr_ok), 32'd0);
        check_eq("pri_addr_d", m_addr, 32'h200);
        cyc(); data_req = 1'b0; #1;
        check_eq("pri_iaok1", 32'(inst_addr_ok), 32'd1);
        check_eq("pri_addr_i", m_addr, 32'h100);
        check_eq("pri_size_i", 32'(m_size), 32'd2);
        check_eq("pri_idle0", 32'(idle), 32'd0);
        cyc(); inst_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'hAA; #1;
        check_eq("pri_r1_ddok", 32'(data_data_ok), 32'd1);
        check_eq("pri_r1_idok", 32'(inst_data_ok), 32'd0);
        check_eq("pri_r1_rdata", data_rdata, 32'hAA);
        cyc(); m_rdata = 32'hBB; #1;
        check_eq("pri_r2_idok", 32'(inst_data_ok), 32'd1);
        check_eq("pri_r2_ddok", 32'(data_data_ok), 32'd0);
        check_eq("pri_r2_rdata", inst_rdata, 32'hBB);
        cyc(); m_data_ok = 1'b0; #1;
        check_eq("pri_idle1", 32'(idle), 32'd1);

        // ---- lock: inst held for 3 refused cycles, data not preempting ----
        cyc(); inst_req = 1'b1; inst_addr = 32'h300; m_addr_ok = 1'b0; #1;
        check_eq("lk_c0_mreq", 32'(m_req), 32'd1);
        check_eq("lk_c0_addr", m_addr, 32'h300);
        check_eq("lk_c0_iaok", 32'(inst_addr_ok), 32'd0);
        cyc(); data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h400;
        data_wstrb = 4'hF; data_wdata = 32'hDEAD; #1;
        check_eq("lk_c1_addr", m_addr, 32'h300);
        check_eq("lk_c1_wr", 32'(m_wr), 32'd0);
        cyc(); #1;
        check_eq("lk_c2_addr", m_addr, 32'h300);
        cyc(); m_addr_ok = 1'b1; #1;
        check_eq("lk_c3_iaok", 32'(inst_addr_ok), 32'd1);
        check_eq("lk_c3_daok", 32'(data_addr_ok), 32'd0);
        check_eq("lk_c3_addr", m_addr, 32'h300);
        cyc(); inst_req = 1'b0; #1;
        check_eq("lk_d_daok", 32'(data_addr_ok), 32'd1);
        check_eq("lk_d_wr", 32'(m_wr), 32'd1);
        check_eq("lk_d_wdata", m_wdata, 32'hDEAD);
        check_eq("lk_d_wstrb", 32'(m_wstrb), 32'hF);
        cyc(); data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h5; #1;
        check_eq("lk_r1_idok", 32'(inst_data_ok), 32'd1);
        cyc(); #1;
        check_eq("lk_r2_ddok", 32'(data_data_ok), 32'd1);
        check_eq("lk_r2_idok", 32'(inst_data_ok), 32'd0);
        cyc(); m_data_ok = 1'b0; #1;
        check_eq("lk_idle", 32'(idle), 32'd1);

        // ---- full: 4 reads, 5th blocked, pop frees a slot next cycle ----
        data_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(); inst_req = 1'b1; inst_addr = 32'h600 + 32'(i * 4); m_addr_ok = 1'b1; #1;
            check_eq($sformatf("full_push%0d", i), 32'(inst_addr_ok), 32'd1);
        end
        cyc(); inst_addr = 32'h610; m_data_ok = 1'b1; m_rdata = 32'h60; #1;
        check_eq("full_mreq0", 32'(m_req), 32'd0);
        check_eq("full_iaok0", 32'(inst_addr_ok), 32'd0);
        check_eq("full_pop_idok", 32'(inst_data_ok), 32'd1);
        check_eq("full_count4", 32'(dut.count_reg), 32'd4);
        cyc(); #1;
        check_eq("full_mreq1", 32'(m_req), 32'd1);
        check_eq("full_iaok1", 32'(inst_addr_ok), 32'd1);
        check_eq("full_pp_idok", 32'(inst_data_ok), 32'd1);
        cyc(); inst_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0; #1;
        check_eq("full_count3", 32'(dut.count_reg), 32'd3);
        for (int i = 0; i < 3; i++) begin
            cyc(); m_data_ok = 1'b1; #1;
            check_eq($sformatf("full_drain%0d", i), 32'(inst_data_ok), 32'd1);
        end
        cyc(); m_data_ok = 1'b0; #1;
        check_eq("full_idle", 32'(idle), 32'd1);

        // ---- routing: inst, data-write, inst, data-read (pointers wrap) ----
        m_addr_ok = 1'b1;
        cyc(); inst_req = 1'b1; inst_addr = 32'h700; data_req = 1'b0; #1;
        check_eq("rt_a_iaok", 32'(inst_addr_ok), 32'd1);
        cyc(); inst_req = 1'b0; data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h800; #1;
        check_eq("rt_b_daok", 32'(data_addr_ok), 32'd1);
        cyc(); inst_req = 1'b1; inst_addr = 32'h704; data_req = 1'b0; #1;
        check_eq("rt_c_iaok", 32'(inst_addr_ok), 32'd1);
        cyc(); inst_req = 1'b0; data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h804; #1;
        check_eq("rt_d_daok", 32'(data_addr_ok), 32'd1);
        cyc(); data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h11; #1;
        check_eq("rt_r1_idok", 32'(inst_data_ok), 32'd1);
        check_eq("rt_r1_ddok", 32'(data_data_ok), 32'd0);
        check_eq("rt_r1_rdata", inst_rdata, 32'h11);
        cyc(); m_rdata = 32'h22; #1;
        check_eq("rt_r2_ddok", 32'(data_data_ok), 32'd1);
        check_eq("rt_r2_idok", 32'(inst_data_ok), 32'd0);
        cyc(); m_rdata = 32'h33; #1;
        check_eq("rt_r3_idok", 32'(inst_data_ok), 32'd1);
        check_eq("rt_r3_rdata", inst_rdata, 32'h33);
        cyc(); m_rdata = 32'h44; #1;
        check_eq("rt_r4_ddok", 32'(data_data_ok), 32'd1);
        check_eq("rt_r4_idok", 32'(inst_data_ok), 32'd0);
        check_eq("rt_r4_rdata", data_rdata, 32'h44);
        cyc(); m_data_ok = 1'b0; #1;
        check_eq("rt_idle", 32'(idle), 32'd1);

        // ---- flush drop: locked data falls, inst granted same cycle ----
        cyc(); inst_req = 1'b1; inst_addr = 32'h900; data_req = 1'b1; data_addr = 32'hA00;
        m_addr_ok = 1'b0; #1;
        check_eq("fl_lock_addr", m_addr, 32'hA00);
        cyc(); data_req = 1'b0; m_addr_ok = 1'b1; #1;
        check_eq("fl_iaok", 32'(inst_addr_ok), 32'd1);
        check_eq("fl_daok", 32'(data_addr_ok), 32'd0);
        check_eq("fl_addr", m_addr, 32'h900);
        cyc(); inst_req = 1'b0; m_addr_ok = 1'b0; #1;
        check_eq("fl_count1", 32'(dut.count_reg), 32'd1);
        m_data_ok = 1'b1; #1;
        check_eq("fl_r_idok", 32'(inst_data_ok), 32'd1);
        cyc(); m_data_ok = 1'b0; #1;
        check_eq("fl_idle", 32'(idle), 32'd1);

        // ---- reset with 3 outstanding, then stray response ----
        for (int i = 0; i < 3; i++) begin
            cyc(); inst_req = 1'b1; inst_addr = 32'hB00 + 32'(i * 4); m_addr_ok = 1'b1; #1;
            check_eq($sformatf("rs_push%0d", i), 32'(inst_addr_ok), 32'd1);
        end
        cyc(); inst_req = 1'b0; m_addr_ok = 1'b0; resetn = 1'b0; #1;
        check_eq("rs_idle_before", 32'(idle), 32'd0);
        cyc(); resetn = 1'b1; #1;
        check_eq("rs_idle_after", 32'(idle), 32'd1);
        check_eq("rs_count", 32'(dut.count_reg), 32'd0);
        m_data_ok = 1'b1; m_rdata = 32'hEE; #1;
        check_eq("err_idok", 32'(inst_data_ok), 32'd0);
        check_eq("err_ddok", 32'(data_data_ok), 32'd0);
        cyc(); m_data_ok = 1'b0; #1;
        check_eq("err_idle", 32'(idle), 32'd1);
        check_eq("err_count", 32'(dut.count_reg), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
